// File: rtl/fht_seq_ctrl_if.sv
// Bundle between fht_seq_ctrl and its environment: sample stream, FHT core
// load/start/readout port, result stream and status. master = sequencer side.
interface fht_seq_ctrl_if #(
  parameter int D_BIT = 16,
  parameter int A_BIT = 8
);
  logic               iVALID;
  logic [D_BIT-2:0]   iSAMPLE;
  logic               oREADY;

  logic [D_BIT-2:0]   oFHT_DATA;
  logic [A_BIT-1:0]   oFHT_ADDR_WR;
  logic [3:0]         oFHT_WE;
  logic               oFHT_START;
  logic               iFHT_RDY;
  logic [A_BIT-1:0]   oFHT_ADDR_RD;
  logic [D_BIT-1:0]   iFHT_DATA_0;
  logic [D_BIT-1:0]   iFHT_DATA_1;
  logic [D_BIT-1:0]   iFHT_DATA_2;
  logic [D_BIT-1:0]   iFHT_DATA_3;

  logic               oOUT_VALID;
  logic [D_BIT-1:0]   oOUT_DATA;
  logic [A_BIT+1:0]   oOUT_INDEX;
  logic               iOUT_READY;

  logic               oBUSY;
  logic               oDONE;

  modport master (
    input  iVALID, iSAMPLE, iFHT_RDY,
           iFHT_DATA_0, iFHT_DATA_1, iFHT_DATA_2, iFHT_DATA_3, iOUT_READY,
    output oREADY, oFHT_DATA, oFHT_ADDR_WR, oFHT_WE, oFHT_START, oFHT_ADDR_RD,
           oOUT_VALID, oOUT_DATA, oOUT_INDEX, oBUSY, oDONE
  );

  modport slave (
    output iVALID, iSAMPLE, iFHT_RDY,
           iFHT_DATA_0, iFHT_DATA_1, iFHT_DATA_2, iFHT_DATA_3, iOUT_READY,
    input  oREADY, oFHT_DATA, oFHT_ADDR_WR, oFHT_WE, oFHT_START, oFHT_ADDR_RD,
           oOUT_VALID, oOUT_DATA, oOUT_INDEX, oBUSY, oDONE
  );
endinterface

// File: rtl/fht_seq_ctrl.sv
// Host sequencer for the FHT core: scatters a sample frame into the 4 banks,
// starts the core, waits for completion and streams results out in index order.
// Define FHT_SEQ_BITREV_EN to bit-reverse the load index before the bank split.
module fht_seq_ctrl #(
  parameter int D_BIT = 16,
  parameter int A_BIT = 8
) (
  input  logic          iCLK,
  input  logic          iRESET,
  fht_seq_ctrl_if.master bus
);
  localparam int IW = A_BIT + 2;
  localparam logic [IW-1:0] LAST = '1;

  typedef enum logic [2:0] {IDLE, LOAD, START, WAIT_LO, WAIT_HI, UNLOAD} state_t;

  state_t          state, state_nxt;
  logic [IW-1:0]   ld_cnt;
  logic [IW-1:0]   ld_map;
  logic [IW-1:0]   rd_cnt;
  logic            rd_all;
  logic            rd_pend;
  logic [IW-1:0]   rd_pend_idx;
  logic [D_BIT-1:0] rd_sel;
  logic [D_BIT-1:0] buf_data [2];
  logic [IW-1:0]   buf_idx [2];
  logic            wr_ptr, rd_ptr;
  logic [1:0]      occ, occ_net;
  logic            accept, issue, pop, last_pop, out_valid;

`ifdef FHT_SEQ_BITREV_EN
  function automatic logic [IW-1:0] bitrev(input logic [IW-1:0] v);
    logic [IW-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < IW; i++) r[i] = v[IW-1-i];
    return r;
  endfunction
  assign ld_map = bitrev(ld_cnt);
`else
  assign ld_map = ld_cnt;
`endif

  always_comb begin
    rd_sel = '0;
    case (rd_pend_idx[1:0])
      2'd0: rd_sel = bus.iFHT_DATA_0;
      2'd1: rd_sel = bus.iFHT_DATA_1;
      2'd2: rd_sel = bus.iFHT_DATA_2;
      2'd3: rd_sel = bus.iFHT_DATA_3;
      default: rd_sel = '0;
    endcase
  end

  always_comb begin
    state_nxt         = state;
    bus.oREADY        = 1'b0;
    bus.oFHT_WE       = '0;
    bus.oFHT_DATA     = '0;
    bus.oFHT_ADDR_WR  = '0;
    bus.oFHT_START    = 1'b0;
    bus.oFHT_ADDR_RD  = '0;
    bus.oBUSY         = (state != IDLE);
    out_valid         = (occ != 2'd0);
    accept            = 1'b0;
    pop               = 1'b0;
    issue             = 1'b0;

    if (state == IDLE || state == LOAD) begin
      bus.oREADY = 1'b1;
      accept     = bus.iVALID;
    end
    if (accept) begin
      bus.oFHT_WE      = 4'b0001 << ld_map[1:0];
      bus.oFHT_DATA    = bus.iSAMPLE;
      bus.oFHT_ADDR_WR = ld_map[IW-1:2];
    end

    if (state == UNLOAD) begin
      pop              = out_valid & bus.iOUT_READY;
      bus.oFHT_ADDR_RD = rd_cnt[IW-1:2];
    end
    last_pop = pop & (buf_idx[rd_ptr] == LAST);
    // Occupancy is taken net of this cycle's pop; counting the leaving entry
    // would stall every other cycle and halve the readout rate.
    occ_net = occ - {1'b0, pop};
    issue   = (state == UNLOAD) & ~rd_all & ((occ_net + {1'b0, rd_pend}) < 2'd2);

    case (state)
      IDLE:    if (accept) state_nxt = LOAD;
      LOAD:    if (accept && ld_cnt == LAST) state_nxt = START;
      START:   state_nxt = WAIT_LO;
      WAIT_LO: if (!bus.iFHT_RDY) state_nxt = WAIT_HI;
      WAIT_HI: if (bus.iFHT_RDY) state_nxt = UNLOAD;
      UNLOAD:  if (last_pop) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (state == START) bus.oFHT_START = 1'b1;
  end

  assign bus.oOUT_VALID = out_valid;
  assign bus.oOUT_DATA  = out_valid ? buf_data[rd_ptr] : '0;
  assign bus.oOUT_INDEX = out_valid ? buf_idx[rd_ptr] : '0;
  assign bus.oDONE      = last_pop;

  always_ff @(posedge iCLK) begin
    if (!iRESET) begin
      state       <= IDLE;
      ld_cnt      <= '0;
      rd_cnt      <= '0;
      rd_all      <= 1'b0;
      rd_pend     <= 1'b0;
      rd_pend_idx <= '0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      occ         <= '0;
      buf_data[0] <= '0;
      buf_data[1] <= '0;
      buf_idx[0]  <= '0;
      buf_idx[1]  <= '0;
    end else begin
      state <= state_nxt;
      if (accept) ld_cnt <= (ld_cnt == LAST) ? '0 : ld_cnt + 1'b1;

      rd_pend <= issue;
      if (issue) begin
        rd_pend_idx <= rd_cnt;
        rd_cnt      <= rd_cnt + 1'b1;
        if (rd_cnt == LAST) rd_all <= 1'b1;
      end

      // Registered core read lands one cycle after issue; capture into the skid buffer.
      if (rd_pend) begin
        buf_data[wr_ptr] <= rd_sel;
        buf_idx[wr_ptr]  <= rd_pend_idx;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      occ <= occ + {1'b0, rd_pend} - {1'b0, pop};

      if (last_pop) begin
        rd_cnt <= '0;
        rd_all <= 1'b0;
      end
    end
  end
endmodule
